// File: rtl/mjp_pkg.sv
// Shared Muk-jji-ppa definitions: move codes, player FSM states
// and small decode helpers used by the player port and game core.
package mjp_pkg;

  typedef enum logic [1:0] {
    ROCK     = 2'b00,
    SCISSORS = 2'b01,
    PAPER    = 2'b10,
    INVALID  = 2'b11
  } move_t;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    DEBOUNCE = 3'd1,
    ARMED    = 3'd2,
    ISSUE    = 3'd3,
    RELEASE  = 3'd4
  } state_t;

  function automatic logic onehot3(
    input logic [2:0] b
  );
    return (b != 3'd0) &&
           ((b & (b - 3'd1)) == 3'd0);
  endfunction

  function automatic move_t btn2move(
    input logic [2:0] b
  );
    move_t m;
    unique case (b)
      3'b001:  m = ROCK;
      3'b010:  m = SCISSORS;
      3'b100:  m = PAPER;
      default: m = INVALID;
    endcase
    return m;
  endfunction

  // INVALID is never a legal generated move.
  function automatic move_t rnd2move(
    input logic [1:0] v
  );
    return (v == 2'b11) ? ROCK : move_t'(v);
  endfunction

endpackage

// File: rtl/mjp_lfsr8.sv
// Free-running 8-bit Fibonacci LFSR, x^8+x^6+x^5+x^4+1.
// Reusable as a CPU opponent source.
module mjp_lfsr8 (
  input  logic       CLK,
  input  logic       RST,
  input  logic [7:0] SEED,
  output logic [7:0] Q
);

  logic fb;

  assign fb = Q[7] ^ Q[5] ^ Q[4] ^ Q[3];

  always_ff @(posedge CLK) begin
    if (!RST) begin
      Q <= SEED;
    end else begin
      Q <= {Q[6:0], fb};
    end
  end

endmodule

// File: rtl/mjp_player_input.sv
// Move transmitter for one player port: debounced buttons or
// pseudo-random auto play, issued for one round per tick.
import mjp_pkg::*;

module mjp_player_input #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter logic [7:0]  LFSR_SEED       = 8'hA5
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [2:0] BTN,
  input  logic       AUTO,
  input  logic       ROUND_TICK,
  output logic [1:0] MOVE,
  output logic       MOVE_VALID,
  output logic       ERR
);

  logic [2:0] btn_s1;
  logic [2:0] sb;
  logic       auto_q;
  state_t     state;
  move_t      cand;
  logic [7:0] cnt;
  logic [8:0] cnt_nxt;
  logic [7:0] lfsr_q;
  logic       sb_one;
  logic       sb_multi;
  move_t      sb_move;
  move_t      rnd_move;
  logic       unused_lfsr;

  mjp_lfsr8 u_lfsr (
    .CLK  (CLK),
    .RST  (RST),
    .SEED (LFSR_SEED),
    .Q    (lfsr_q)
  );

  assign sb_one      = onehot3(sb);
  assign sb_multi    = (sb != 3'd0) && !sb_one;
  assign sb_move     = btn2move(sb);
  assign rnd_move    = rnd2move(lfsr_q[1:0]);
  assign cnt_nxt     = {1'b0, cnt} + 9'd1;
  assign unused_lfsr = ^lfsr_q[7:2];

  always_ff @(posedge CLK) begin
    if (!RST) begin
      btn_s1     <= 3'd0;
      sb         <= 3'd0;
      auto_q     <= 1'b0;
      state      <= IDLE;
      cand       <= ROCK;
      cnt        <= 8'd0;
      MOVE       <= INVALID;
      MOVE_VALID <= 1'b0;
      ERR        <= 1'b0;
    end else begin
      btn_s1     <= BTN;
      sb         <= btn_s1;
      auto_q     <= AUTO;
      MOVE       <= INVALID;
      MOVE_VALID <= 1'b0;
      ERR        <= 1'b0;

      // A mode flip drops anything pending, but an issuing
      // move is allowed to finish its round.
      if (state != ISSUE && auto_q != AUTO) begin
        state <= IDLE;
        cnt   <= 8'd0;
      end else begin
        unique case (state)
          IDLE: begin
            if (auto_q) begin
              if (ROUND_TICK) begin
                cand       <= rnd_move;
                MOVE       <= rnd_move;
                MOVE_VALID <= 1'b1;
                state      <= ISSUE;
              end
            end else if (sb_one) begin
              cand  <= sb_move;
              cnt   <= 8'd1;
              state <= DEBOUNCE;
            end else if (sb_multi) begin
              ERR <= 1'b1;
            end
          end

          DEBOUNCE: begin
            if (sb_one && sb_move == cand) begin
              cnt <= cnt_nxt[7:0];
              if (cnt_nxt >= 9'(DEBOUNCE_CYCLES)) begin
                state <= ARMED;
              end
            end else if (sb_one) begin
              cand <= sb_move;
              cnt  <= 8'd1;
            end else if (sb == 3'd0) begin
              cnt   <= 8'd0;
              state <= IDLE;
            end else begin
              ERR   <= 1'b1;
              cnt   <= 8'd0;
              state <= IDLE;
            end
          end

          ARMED: begin
            if (ROUND_TICK) begin
              MOVE       <= cand;
              MOVE_VALID <= 1'b1;
              cnt        <= 8'd0;
              state      <= ISSUE;
            end
          end

          ISSUE: begin
            state <= auto_q ? IDLE : RELEASE;
          end

          RELEASE: begin
            if (sb == 3'd0) begin
              state <= IDLE;
            end
          end

          default: begin
            cnt   <= 8'd0;
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mjp_player_input.sv
// Randomized scenario bench for mjp_player_input with a
// behavioural move/LFSR reference model.
module tb_mjp_player_input;

  localparam logic [7:0] SEED = 8'hA5;

  logic       clk;
  logic       rst_n;
  logic [2:0] btn;
  logic       auto_mode;
  logic       tick;
  logic [1:0] move;
  logic       move_valid;
  logic       err;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] m_lfsr = 8'h00;

  mjp_player_input #(
    .DEBOUNCE_CYCLES (4),
    .LFSR_SEED       (SEED)
  ) dut (
    .CLK        (clk),
    .RST        (rst_n),
    .BTN        (btn),
    .AUTO       (auto_mode),
    .ROUND_TICK (tick),
    .MOVE       (move),
    .MOVE_VALID (move_valid),
    .ERR        (err)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  // Polynomial x^8+x^6+x^5+x^4+1 as a tap mask.
  function automatic logic [7:0] lfsr_step(input logic [7:0] s);
    return {s[6:0], ^(s & 8'b1011_1000)};
  endfunction

  always @(posedge clk) begin
    if (!rst_n) m_lfsr <= SEED;
    else        m_lfsr <= lfsr_step(m_lfsr);
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic tick_obs(output logic [1:0] mv,
                          output logic v,
                          output logic [7:0] pre);
    @(negedge clk);
    tick = 1'b1;
    pre  = m_lfsr;
    @(negedge clk);
    tick = 1'b0;
    mv   = move;
    v    = move_valid;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    wait_cyc(2);
    n_checks++;
    if (move !== 2'b11) begin
      n_fail++;
      $display("FAIL reset_move got %b want 11", move);
    end
    n_checks++;
    if (move_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_valid got %b want 0", move_valid);
    end
    n_checks++;
    if (err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_err got %b want 0", err);
    end
    n_checks++;
    if (dut.u_lfsr.Q !== SEED) begin
      n_fail++;
      $display("FAIL reset_lfsr got %h want %h", dut.u_lfsr.Q, SEED);
    end
    rst_n = 1'b1;
    wait_cyc(1);
    n_checks++;
    if (dut.u_lfsr.Q !== lfsr_step(SEED)) begin
      n_fail++;
      $display("FAIL lfsr_first_step got %h want %h",
               dut.u_lfsr.Q, lfsr_step(SEED));
    end
  endtask

  task automatic test_manual_rock;
    logic [1:0] mv;
    logic v;
    logic [7:0] pre;
    btn = 3'b001;
    wait_cyc(8);
    tick_obs(mv, v, pre);
    n_checks++;
    if (mv !== 2'b00 || v !== 1'b1) begin
      n_fail++;
      $display("FAIL rock_issue got %b/%b want 00/1", mv, v);
    end
    wait_cyc(1);
    n_checks++;
    if (move !== 2'b11 || move_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rock_after got %b/%b want 11/0", move, move_valid);
    end
    for (int k = 0; k < 10; k++) begin
      tick_obs(mv, v, pre);
      n_checks++;
      if (v !== 1'b0 || mv !== 2'b11) begin
        n_fail++;
        $display("FAIL rock_held_%0d got %b/%b want 11/0", k, mv, v);
      end
      wait_cyc(1);
    end
    btn = 3'b000;
    wait_cyc(4);
  endtask

  task automatic test_bounce;
    logic [1:0] mv;
    logic v;
    logic [7:0] pre;
    int bad = 0;
    for (int k = 0; k < 12; k++) begin
      btn  = ((k / 2) % 2 == 0) ? 3'b001 : 3'b000;
      tick = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (move_valid !== 1'b0 || move !== 2'b11) bad++;
    end
    tick = 1'b0;
    btn  = 3'b000;
    wait_cyc(2);
    if (move_valid !== 1'b0) bad++;
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL bounce_quiet got %0d bad cycles want 0", bad);
    end
    tick_obs(mv, v, pre);
    n_checks++;
    if (v !== 1'b0) begin
      n_fail++;
      $display("FAIL bounce_tick got valid %b want 0", v);
    end
    btn = 3'b100;
    wait_cyc(8);
    tick_obs(mv, v, pre);
    n_checks++;
    if (mv !== 2'b10 || v !== 1'b1) begin
      n_fail++;
      $display("FAIL bounce_paper got %b/%b want 10/1", mv, v);
    end
    btn = 3'b000;
    wait_cyc(4);
  endtask

  task automatic test_multi_press;
    logic [1:0] mv;
    logic v;
    logic [7:0] pre;
    logic seen;
    btn  = 3'b011;
    seen = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      seen |= err;
    end
    n_checks++;
    if (seen !== 1'b1) begin
      n_fail++;
      $display("FAIL multi_idle_err got %b want 1", seen);
    end
    tick_obs(mv, v, pre);
    n_checks++;
    if (v !== 1'b0 || mv !== 2'b11) begin
      n_fail++;
      $display("FAIL multi_no_move got %b/%b want 11/0", mv, v);
    end
    btn = 3'b000;
    wait_cyc(4);
    btn = 3'b001;
    wait_cyc(3);
    btn  = 3'b101;
    seen = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      seen |= err;
    end
    n_checks++;
    if (seen !== 1'b1) begin
      n_fail++;
      $display("FAIL multi_deb_err got %b want 1", seen);
    end
    tick_obs(mv, v, pre);
    n_checks++;
    if (v !== 1'b0) begin
      n_fail++;
      $display("FAIL multi_deb_no_move got valid %b want 0", v);
    end
    btn = 3'b000;
    wait_cyc(4);
    n_checks++;
    if (err !== 1'b0) begin
      n_fail++;
      $display("FAIL multi_err_clear got %b want 0", err);
    end
  endtask

  task automatic test_missed_tick;
    logic [1:0] mv;
    logic v;
    logic [7:0] pre;
    btn = 3'b010;
    wait_cyc(5);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    n_checks++;
    if (move !== 2'b11 || move_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL missed_tick got %b/%b want 11/0", move, move_valid);
    end
    wait_cyc(2);
    tick_obs(mv, v, pre);
    n_checks++;
    if (mv !== 2'b01 || v !== 1'b1) begin
      n_fail++;
      $display("FAIL missed_next got %b/%b want 01/1", mv, v);
    end
    btn = 3'b000;
    wait_cyc(4);
  endtask

  task automatic test_random_manual;
    logic [1:0] mv;
    logic v;
    logic [7:0] pre;
    int i;
    for (int r = 0; r < 8; r++) begin
      i   = int'($urandom_range(0, 2));
      btn = 3'(1 << i);
      wait_cyc(int'($urandom_range(7, 12)));
      if ($urandom_range(0, 1) == 1) begin
        btn = 3'b000;
        wait_cyc(int'($urandom_range(1, 4)));
      end
      tick_obs(mv, v, pre);
      n_checks++;
      if (mv !== 2'(i) || v !== 1'b1) begin
        n_fail++;
        $display("FAIL rand_manual_%0d got %b/%b want %b/1",
                 r, mv, v, 2'(i));
      end
      btn = 3'b000;
      wait_cyc(4);
    end
  endtask

  task automatic test_auto;
    logic [1:0] mv;
    logic [1:0] exp;
    logic v;
    logic [7:0] pre;
    int errs = 0;
    int pulses;
    auto_mode = 1'b1;
    wait_cyc(2);
    for (int r = 0; r < 20; r++) begin
      for (int g = 0; g < int'($urandom_range(1, 3)); g++) begin
        btn = 3'($urandom_range(0, 7));
        @(negedge clk);
        if (err !== 1'b0) errs++;
      end
      tick_obs(mv, v, pre);
      exp = (pre[1:0] == 2'b11) ? 2'b00 : pre[1:0];
      n_checks++;
      if (mv !== exp || v !== 1'b1 || mv === 2'b11) begin
        n_fail++;
        $display("FAIL auto_%0d got %b/%b want %b/1 (lfsr %h)",
                 r, mv, v, exp, pre);
      end
    end
    btn = 3'b000;
    wait_cyc(1);
    n_checks++;
    if (errs != 0) begin
      n_fail++;
      $display("FAIL auto_err got %0d pulses want 0", errs);
    end
    pulses = 0;
    tick   = 1'b1;
    @(negedge clk);
    if (move_valid === 1'b1) pulses++;
    @(negedge clk);
    tick = 1'b0;
    if (move_valid === 1'b1) pulses++;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (move_valid === 1'b1) pulses++;
    end
    n_checks++;
    if (pulses != 1) begin
      n_fail++;
      $display("FAIL auto_issue_tick got %0d moves want 1", pulses);
    end
  endtask

  task automatic test_mode_change;
    logic [1:0] mv;
    logic v;
    logic [7:0] pre;
    auto_mode = 1'b0;
    wait_cyc(3);
    btn = 3'b001;
    wait_cyc(8);
    btn = 3'b000;
    wait_cyc(3);
    auto_mode = 1'b1;
    tick      = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    n_checks++;
    if (move_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL mode_vs_tick got valid %b want 0", move_valid);
    end
    wait_cyc(2);
    auto_mode = 1'b0;
    wait_cyc(3);
    tick_obs(mv, v, pre);
    n_checks++;
    if (v !== 1'b0 || mv !== 2'b11) begin
      n_fail++;
      $display("FAIL mode_dropped got %b/%b want 11/0", mv, v);
    end
  endtask

  task automatic test_reset_abort;
    logic [1:0] mv;
    logic v;
    logic [7:0] pre;
    btn = 3'b100;
    wait_cyc(8);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    btn   = 3'b000;
    wait_cyc(3);
    tick_obs(mv, v, pre);
    n_checks++;
    if (v !== 1'b0 || mv !== 2'b11) begin
      n_fail++;
      $display("FAIL reset_abort got %b/%b want 11/0", mv, v);
    end
    btn = 3'b010;
    wait_cyc(8);
    tick_obs(mv, v, pre);
    n_checks++;
    if (mv !== 2'b01 || v !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_recover got %b/%b want 01/1", mv, v);
    end
    btn = 3'b000;
    wait_cyc(4);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout want finish");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

  initial begin
    rst_n     = 1'b0;
    btn       = 3'b000;
    auto_mode = 1'b0;
    tick      = 1'b0;
    test_reset();
    test_manual_rock();
    test_bounce();
    test_multi_press();
    test_missed_tick();
    test_random_manual();
    test_auto();
    test_mode_change();
    test_reset_abort();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
